// File: rtl/req_ack_fifo_source.sv
// req_ack_fifo_source: buffered responder end of the req/ack pull protocol.
// Local logic pushes words into a FIFO. A downstream requester pulls them one at a
// time with a level req. Each pull is answered with a one-cycle ack, and dout is
// registered on the same edge that ack rises.
// Optional feature: define REQ_ACK_FIFO_SOURCE_STARVE_EN to add the starve_cycles
// output. That counter records the cycles where req waited on an empty FIFO.
module req_ack_fifo_source #(
    parameter int unsigned           data_width    = 32,
    parameter int unsigned           depth_log2    = 3,
    parameter logic [data_width-1:0] initial_value = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [data_width-1:0] wr_data,
    output logic                  full,
    output logic                  overflow,
    input  logic                  req,
    output logic                  ack,
    output logic [data_width-1:0] dout,
    output logic [31:0]           count,
`ifdef REQ_ACK_FIFO_SOURCE_STARVE_EN
    output logic [31:0]           starve_cycles,
`endif
    output logic [depth_log2:0]   level
);

    localparam int unsigned DEPTH = 2 ** depth_log2;
    localparam int unsigned LW    = depth_log2 + 1;
    localparam int unsigned PW    = depth_log2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;

    // Write/read counters carry one extra wrap bit, so occupancy is their difference.
    logic [LW-1:0]         wr_cnt_q;
    logic [LW-1:0]         rd_cnt_q;
    logic [LW-1:0]         wr_cnt_d;
    logic [LW-1:0]         rd_cnt_d;
    logic [LW-1:0]         level_d;

    logic [PW-1:0]         wr_ptr_c;
    logic [PW-1:0]         rd_ptr_c;

    logic [data_width-1:0] mem [DEPTH];

    logic                  pop_c;
    logic                  push_c;
    logic                  drop_c;
    logic                  level_nz_c;

    assign ack        = (state_q == GRANT);
    assign level_nz_c = (level != '0);
    assign wr_ptr_c   = wr_cnt_q[PW-1:0];
    assign rd_ptr_c   = rd_cnt_q[PW-1:0];

    // A pop can free the slot in the same cycle, so a push while full is still accepted.
    assign push_c = wr_en & (~full | pop_c);
    assign drop_c = wr_en & full & ~pop_c;

    // Ack toggle state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Serve rule: grant only from IDLE, which rules out back-to-back acks.
    always_comb begin
        state_d = IDLE;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && level_nz_c) begin
                    state_d = GRANT;
                    pop_c   = 1'b1;
                end
            end
            GRANT: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next counter values and the occupancy that results from them.
    always_comb begin
        wr_cnt_d = wr_cnt_q + LW'(push_c);
        rd_cnt_d = rd_cnt_q + LW'(pop_c);
        level_d  = wr_cnt_d - rd_cnt_d;
    end

    // Pointer, occupancy and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            level    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            level    <= level_d;
            full     <= (level_d == LW'(DEPTH));
            if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage array. It has no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            mem[wr_ptr_c] <= wr_data;
        end
    end

    // Served word and transfer count. Both update only on the edge where ack rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout  <= initial_value;
            count <= '0;
        end else if (pop_c) begin
            dout  <= mem[rd_ptr_c];
            count <= count + 32'd1;
        end
    end

`ifdef REQ_ACK_FIFO_SOURCE_STARVE_EN
    // Saturating count of cycles where the requester waits on an empty FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cycles <= '0;
        end else if (req && !ack && !level_nz_c && (starve_cycles != 32'hFFFF_FFFF)) begin
            starve_cycles <= starve_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_req_ack_fifo_source.sv
// Bench for req_ack_fifo_source. It combines directed scenarios with a randomized
// stream, and checks every cycle against a queue-based reference model.
module tb_req_ack_fifo_source;

    localparam int unsigned DW    = 32;
    localparam int unsigned DL2   = 3;
    localparam int          DEPTH = 8;

    logic            clk;
    logic            rst;
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic            full;
    logic            overflow;
    logic            req;
    logic            ack;
    logic [DW-1:0]   dout;
    logic [31:0]     count;
    logic [DL2:0]    level;
`ifdef REQ_ACK_FIFO_SOURCE_STARVE_EN
    logic [31:0]     starve_cycles;
`endif

    req_ack_fifo_source #(
        .data_width   (DW),
        .depth_log2   (DL2),
        .initial_value('0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .full    (full),
        .overflow(overflow),
        .req     (req),
        .ack     (ack),
        .dout    (dout),
        .count   (count),
`ifdef REQ_ACK_FIFO_SOURCE_STARVE_EN
        .starve_cycles(starve_cycles),
`endif
        .level   (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: the FIFO contents as a queue, plus the expected outputs.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] sb_q[$];
    logic          m_ack     = 1'b0;
    logic          m_ovf     = 1'b0;
    logic [DW-1:0] m_dout    = '0;
    logic [31:0]   m_cnt     = '0;
    logic [31:0]   m_starve  = '0;
    bit            started   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each active edge, using the inputs applied for that edge.
    always @(posedge clk) begin
        bit serve;
        bit was_full;
        started = 1'b1;
        if (rst) begin
            mq.delete();
            sb_q.delete();
            m_ack    = 1'b0;
            m_ovf    = 1'b0;
            m_dout   = '0;
            m_cnt    = '0;
            m_starve = '0;
        end else begin
            serve    = req && !m_ack && (mq.size() != 0);
            was_full = (mq.size() == DEPTH);
            if (req && !m_ack && mq.size() == 0 && m_starve != 32'hFFFF_FFFF)
                m_starve = m_starve + 1;
            if (serve) begin
                m_dout = mq.pop_front();
                sb_q.push_back(m_dout);
                m_cnt  = m_cnt + 1;
            end
            if (wr_en) begin
                if (!was_full || serve) mq.push_back(wr_data);
                else m_ovf = 1'b1;
            end
            m_ack = serve;
        end
    end

    // Monitor: check outputs mid-cycle; served words are popped from the scoreboard.
    always @(negedge clk) begin
        if (started) begin
            check("ack", 64'(ack), 64'(m_ack));
            if (ack === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_underflow: ack seen with no expected word at %0t", $time);
                end else begin
                    check("dout_served", 64'(dout), 64'(sb_q.pop_front()));
                end
            end else begin
                check("dout_held", 64'(dout), 64'(m_dout));
            end
            check("level", 64'(level), 64'(mq.size()));
            check("full", 64'(full), 64'(mq.size() == DEPTH));
            check("overflow", 64'(overflow), 64'(m_ovf));
            check("count", 64'(count), 64'(m_cnt));
`ifdef REQ_ACK_FIFO_SOURCE_STARVE_EN
            check("starve_cycles", 64'(starve_cycles), 64'(m_starve));
`endif
        end
    end

    // Apply one cycle of inputs at the falling edge, then move to the next falling edge.
    task automatic step(input logic r_st, input logic we, input logic [DW-1:0] wd, input logic rq);
        rst     = r_st;
        wr_en   = we;
        wr_data = wd;
        req     = rq;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; req = 1'b0;
        @(negedge clk);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // Push 1,2,3, then hold req high: acks alternate, and there is no fourth ack.
        for (int i = 1; i <= 3; i++) step(0, 1, DW'(i), 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Push 9 words into depth 8: full after 8, overflow after 9, then drain 8.
        for (int i = 1; i <= 9; i++) step(0, 1, DW'(32'h100 + i), 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Full FIFO with a push and a pull on the same edge: the push is accepted.
        step(1, 0, 0, 0);
        for (int i = 1; i <= 8; i++) step(0, 1, DW'(32'h200 + i), 0);
        step(0, 1, 32'h2FF, 1);
        step(0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1);

        // Empty FIFO with req high for 5 cycles, then push 0xA5 while req stays high.
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        step(0, 1, 32'hA5, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Randomized stream, with a reset asserted in the middle of a transfer.
        begin
            logic rq = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                logic we;
                logic rs;
                if ($urandom_range(0, 3) == 0) rq = ~rq;
                we = ($urandom_range(0, 99) < 45);
                rs = ($urandom_range(0, 499) == 0);
                if (i == 1500) begin
                    int guard = 0;
                    while (!m_ack && guard < 50) begin
                        step(0, 1, $urandom, 1);
                        guard++;
                    end
                    if (!m_ack) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL mid_transfer_setup: no ack within 50 cycles at %0t", $time);
                    end
                    step(1, 0, 0, 1);
                end else begin
                    step(rs, we, $urandom, rq);
                end
            end
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
